mf_line_sched: RTL and testbench
================================

Name: mf_line_sched

Overview:
- Controller and scheduler for the 3x3 window filter datapath and its three-bank line buffer.
- Tracks pixel and line position within a frame and rotates the bank being written.
- Tells the datapath which banks hold the top, middle and bottom rows of the window, and when a full 3x3 window is valid.
- Sits between the camera/line source (ILINE/VSYNC) and the filter arithmetic; the datapath owns the memories and the arithmetic.

Parameters:
- pLineSize, 640, line-buffer depth in pixels; maximum accepted pixels per line.
- pXW, 10, width of the X/WADDR/LINE_LEN counters; must satisfy 2^pXW > pLineSize.
- pYW, 10, width of the Y counter.

Ports:
- CLK  in  1  pixel clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- VSYNC  in  1  frame separator; has priority over ILINE.
- ILINE  in  1  a pixel is presented this cycle.
- WE  out  1  write enable to the line buffer.
- WADDR  out  pXW  write address, i.e. the pixel column.
- WBANK  out  2  bank written this line (0..2).
- RBANK_TOP  out  2  bank holding row y-2.
- RBANK_MID  out  2  bank holding row y-1.
- RBANK_BOT  out  2  bank holding the current row (always equals WBANK).
- WIN_VALID  out  1  the 3x3 window ending at column WADDR is complete.
- LINE_DONE  out  1  one-cycle pulse after each line ends.
- LINE_LEN  out  pXW  pixel count of the last line, saturating at 2^pXW-1; updated with LINE_DONE.
- OVF  out  1  sticky flag: a line exceeded pLineSize pixels; cleared by VSYNC.
- Y  out  pYW  current line index within the frame, saturating.

Behaviour:
- Reset values:
  - State = S_WAIT.
  - WE=0, WADDR=0, WBANK=0, RBANK_BOT=0, RBANK_MID=2, RBANK_TOP=1.
  - WIN_VALID=0, LINE_DONE=0, LINE_LEN=0, OVF=0, Y=0.
  - Internal x=0, line-active flag=0.
- Bank mapping (invariant at all times):
  - RBANK_MID = (WBANK+2) mod 3.
  - RBANK_TOP = (WBANK+1) mod 3.
- Timing: all outputs are registered. The response to an input cycle appears on the next rising edge (latency 1). The datapath delays IDATA by one register so it aligns with WE/WADDR.
- States:
  - S_WAIT: ILINE is ignored. VSYNC goes to S_PRIME.
  - S_PRIME: rows 0..1 are being filled.
  - S_RUN: row 2 onward.
- VSYNC high (any state):
  - x=0, Y=0, WBANK=0 (RBANK updated per mapping).
  - WE=0, WIN_VALID=0, OVF=0, line-active=0, LINE_DONE=0.
  - Next state = S_PRIME.
  - A line in progress is abandoned: no LINE_DONE, no bank rotation.
- ILINE high, VSYNC low, state is S_PRIME or S_RUN:
  - If x < pLineSize: WE=1, WADDR=x, x=x+1.
  - Otherwise: WE=0, OVF=1, x holds.
  - The LINE_LEN shadow counter increments, saturating.
  - line-active=1.
  - WIN_VALID=1 iff state is S_RUN, x>=2 and x<pLineSize (the window centre is at column x-1, row Y-1). Otherwise WIN_VALID=0.
- ILINE low with line-active=1 (end of line):
  - LINE_DONE=1 for exactly one cycle; LINE_LEN = shadow count.
  - x=0, shadow=0, line-active=0.
  - WBANK=(WBANK+1) mod 3.
  - Y=Y+1, saturating at 2^pYW-1.
  - If state is S_PRIME and the new Y equals 2, go to S_RUN.
  - WE=0, WIN_VALID=0.
- ILINE low with line-active=0: idle. WE=0, WIN_VALID=0, LINE_DONE=0.
- Back-to-back lines: a single ILINE-low cycle is sufficient to end a line. ILINE may rise again on the following cycle.
- A zero-length gap (ILINE continuously high) is one line; it ends only when ILINE drops.
- RST asserted mid-line: immediate return to reset values. No LINE_DONE is generated.

Test Plan:
- RST, then ILINE high for 5 cycles with no VSYNC -> WE stays 0 and state stays S_WAIT; LINE_DONE never pulses.
- VSYNC, then three lines of 8 pixels with 2-cycle gaps:
  - WADDR 0..7 on each line; WBANK sequence 0,1,2.
  - WIN_VALID=0 on lines 0 and 1.
  - On line 2, WIN_VALID=1 for WADDR 2..7 (6 cycles), with RBANK_TOP=0, RBANK_MID=1, RBANK_BOT=2.
- Line of pLineSize+3 pixels -> WE drops after WADDR=pLineSize-1; OVF=1; LINE_LEN=pLineSize+3; the next VSYNC clears OVF.
- VSYNC asserted at pixel 4 of line 1 -> WBANK=0, Y=0, no LINE_DONE; the next line writes bank 0 starting at WADDR 0.
- Two 4-pixel lines separated by a single ILINE-low cycle -> LINE_DONE pulses once per line, LINE_LEN=4 each, WBANK rotates 0 to 1 to 2.
- RST pulsed asynchronously mid-line (between clock edges) -> outputs reach reset values before the next edge; ILINE is then ignored until VSYNC.

Source files
------------

// File: rtl/mf_line_sched.sv
// mf_line_sched: position tracker and bank scheduler for a 3x3 window filter
// fed from a three-bank line buffer.
//
// Ports:
//   CLK        pixel clock, rising edge
//   RST        asynchronous active-high reset
//   VSYNC      frame separator, overrides ILINE
//   ILINE      pixel valid this cycle
//   WE/WADDR   line-buffer write enable / column address
//   WBANK      bank being written this line (0..2)
//   RBANK_TOP  bank holding row y-2
//   RBANK_MID  bank holding row y-1
//   RBANK_BOT  bank holding the current row (same as WBANK)
//   WIN_VALID  3x3 window ending at column WADDR is complete
//   LINE_DONE  one-cycle pulse after each line ends
//   LINE_LEN   pixel count of the last line (saturating)
//   OVF        sticky: a line exceeded pLineSize pixels; cleared by VSYNC
//   Y          line index within the frame (saturating)
//
// All outputs are registered: the response to an input cycle appears after
// the next rising edge.

module mf_line_sched #(
   parameter int unsigned pLineSize = 640,
   parameter int unsigned pXW       = 10,
   parameter int unsigned pYW       = 10
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           VSYNC,
   input  logic           ILINE,
   output logic           WE,
   output logic [pXW-1:0] WADDR,
   output logic [1:0]     WBANK,
   output logic [1:0]     RBANK_TOP,
   output logic [1:0]     RBANK_MID,
   output logic [1:0]     RBANK_BOT,
   output logic           WIN_VALID,
   output logic           LINE_DONE,
   output logic [pXW-1:0] LINE_LEN,
   output logic           OVF,
   output logic [pYW-1:0] Y
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_PRIME,
      S_RUN
   } state_t;

   localparam logic [pXW-1:0] LineMax = pXW'(pLineSize);
   localparam logic [pXW-1:0] XSat    = '1;
   localparam logic [pXW-1:0] XTwo    = pXW'(2);
   localparam logic [pYW-1:0] YSat    = '1;
   localparam logic [pYW-1:0] YTwo    = pYW'(2);

   // Modulo-3 bank arithmetic.
   function automatic logic [1:0] bank_inc(input logic [1:0] b);
      return (b == 2'd2) ? 2'd0 : b + 2'd1;
   endfunction

   function automatic logic [1:0] bank_dec(input logic [1:0] b);
      return (b == 2'd0) ? 2'd2 : b - 2'd1;
   endfunction

   state_t         state_q, state_d;
   logic [pXW-1:0] x_q, x_d;
   logic           act_q, act_d;
   logic [pXW-1:0] shadow_q, shadow_d;
   logic           we_q, we_d;
   logic [pXW-1:0] waddr_q, waddr_d;
   logic [1:0]     wbank_q, wbank_d;
   logic [1:0]     rtop_q, rtop_d;
   logic [1:0]     rmid_q, rmid_d;
   logic           win_valid_q, win_valid_d;
   logic           line_done_q, line_done_d;
   logic [pXW-1:0] line_len_q, line_len_d;
   logic           ovf_q, ovf_d;
   logic [pYW-1:0] y_q, y_d;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      act_d       = act_q;
      shadow_d    = shadow_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wbank_d     = wbank_q;
      win_valid_d = 1'b0;
      line_done_d = 1'b0;
      line_len_d  = line_len_q;
      ovf_d       = ovf_q;
      y_d         = y_q;

      if (VSYNC) begin
         // Abandon any line in progress: no LINE_DONE, no rotation.
         x_d      = '0;
         y_d      = '0;
         wbank_d  = 2'd0;
         ovf_d    = 1'b0;
         act_d    = 1'b0;
         shadow_d = '0;
         state_d  = S_PRIME;
      end else if (ILINE && (state_q != S_WAIT)) begin
         if (x_q < LineMax) begin
            we_d    = 1'b1;
            waddr_d = x_q;
            x_d     = x_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
         if (shadow_q != XSat) begin
            shadow_d = shadow_q + 1'b1;
         end
         act_d = 1'b1;
         // Window centre sits at column x-1 of row Y-1.
         win_valid_d = (state_q == S_RUN) && (x_q >= XTwo) && (x_q < LineMax);
      end else if (!ILINE && act_q) begin
         line_done_d = 1'b1;
         line_len_d  = shadow_q;
         x_d         = '0;
         shadow_d    = '0;
         act_d       = 1'b0;
         wbank_d     = bank_inc(wbank_q);
         if (y_q != YSat) begin
            y_d = y_q + 1'b1;
         end
         if ((state_q == S_PRIME) && (y_d == YTwo)) begin
            state_d = S_RUN;
         end
      end

      // Read banks follow the write bank so the mapping holds every cycle.
      rtop_d = bank_inc(wbank_d);
      rmid_d = bank_dec(wbank_d);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_WAIT;
         x_q         <= '0;
         act_q       <= 1'b0;
         shadow_q    <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wbank_q     <= 2'd0;
         rtop_q      <= 2'd1;
         rmid_q      <= 2'd2;
         win_valid_q <= 1'b0;
         line_done_q <= 1'b0;
         line_len_q  <= '0;
         ovf_q       <= 1'b0;
         y_q         <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         act_q       <= act_d;
         shadow_q    <= shadow_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wbank_q     <= wbank_d;
         rtop_q      <= rtop_d;
         rmid_q      <= rmid_d;
         win_valid_q <= win_valid_d;
         line_done_q <= line_done_d;
         line_len_q  <= line_len_d;
         ovf_q       <= ovf_d;
         y_q         <= y_d;
      end
   end

   assign WE        = we_q;
   assign WADDR     = waddr_q;
   assign WBANK     = wbank_q;
   assign RBANK_TOP = rtop_q;
   assign RBANK_MID = rmid_q;
   assign RBANK_BOT = wbank_q;
   assign WIN_VALID = win_valid_q;
   assign LINE_DONE = line_done_q;
   assign LINE_LEN  = line_len_q;
   assign OVF       = ovf_q;
   assign Y         = y_q;

endmodule

// File: tb/tb_mf_line_sched.sv
// Self-checking bench for mf_line_sched. Expected outputs are pushed to a
// queue as each input cycle is driven and popped/compared after the edge.

module tb_mf_line_sched;

   localparam int L = 640;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       VSYNC = 1'b0;
   logic       ILINE = 1'b0;
   logic       WE;
   logic [9:0] WADDR;
   logic [1:0] WBANK, RBANK_TOP, RBANK_MID, RBANK_BOT;
   logic       WIN_VALID, LINE_DONE;
   logic [9:0] LINE_LEN;
   logic       OVF;
   logic [9:0] Y;

   mf_line_sched #(.pLineSize(L), .pXW(10), .pYW(10)) dut (
      .CLK(CLK), .RST(RST), .VSYNC(VSYNC), .ILINE(ILINE),
      .WE(WE), .WADDR(WADDR), .WBANK(WBANK),
      .RBANK_TOP(RBANK_TOP), .RBANK_MID(RBANK_MID), .RBANK_BOT(RBANK_BOT),
      .WIN_VALID(WIN_VALID), .LINE_DONE(LINE_DONE), .LINE_LEN(LINE_LEN),
      .OVF(OVF), .Y(Y)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       we;
      logic [9:0] waddr;
      logic [1:0] wbank;
      logic [1:0] rtop;
      logic [1:0] rmid;
      logic [1:0] rbot;
      logic       wv;
      logic       ld;
      logic [9:0] len;
      logic       ovf;
      logic [9:0] y;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Behavioural model state, written from the frame/line semantics.
   int m_x, m_sh, m_len, m_wbank, m_y;
   bit m_ovf, m_act, m_armed;

   function automatic obs_t mk(input bit we, input int waddr, input bit wv, input bit ld);
      obs_t e;
      e.we    = we;
      e.waddr = we ? 10'(waddr) : 10'd0;
      e.wbank = 2'(m_wbank);
      e.rtop  = 2'((m_wbank + 1) % 3);
      e.rmid  = 2'((m_wbank + 2) % 3);
      e.rbot  = 2'(m_wbank);
      e.wv    = wv;
      e.ld    = ld;
      e.len   = 10'(m_len);
      e.ovf   = m_ovf;
      e.y     = 10'(m_y);
      return e;
   endfunction

   function automatic void model_reset();
      m_x = 0; m_sh = 0; m_len = 0; m_wbank = 0; m_y = 0;
      m_ovf = 0; m_act = 0; m_armed = 0;
   endfunction

   function automatic obs_t vs_exp();
      m_x = 0; m_sh = 0; m_wbank = 0; m_y = 0; m_ovf = 0; m_act = 0; m_armed = 1;
      return mk(0, 0, 0, 0);
   endfunction

   // One ILINE-high cycle while armed.
   function automatic obs_t px_exp();
      bit we, wv;
      int a;
      a  = m_x;
      we = (m_x < L);
      wv = m_armed && (m_y >= 2) && (m_x >= 2) && (m_x < L);
      if (we) m_x++;
      else m_ovf = 1;
      if (m_sh < 1023) m_sh++;
      m_act = 1;
      return mk(we, a, wv, 0);
   endfunction

   // ILINE-low cycle: ends the line if one is active, else idle.
   function automatic obs_t low_exp();
      if (!m_act) return mk(0, 0, 0, 0);
      m_len = m_sh; m_sh = 0; m_x = 0; m_act = 0;
      m_wbank = (m_wbank + 1) % 3;
      if (m_y < 1023) m_y++;
      return mk(0, 0, 0, 1);
   endfunction

   function automatic obs_t sample(input bit use_waddr);
      obs_t g;
      g.we = WE; g.waddr = use_waddr ? WADDR : 10'd0; g.wbank = WBANK;
      g.rtop = RBANK_TOP; g.rmid = RBANK_MID; g.rbot = RBANK_BOT;
      g.wv = WIN_VALID; g.ld = LINE_DONE; g.len = LINE_LEN; g.ovf = OVF; g.y = Y;
      return g;
   endfunction

   task automatic tick(input logic vs, input logic il);
      VSYNC = vs;
      ILINE = il;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, g;
      RST = 1'b1;
      model_reset();
      @(posedge CLK); #1;
      RST = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0));
      e = exp_q.pop_front(); g = sample(e.we); checks++;
      if (g !== e) begin
         failures++; $display("FAIL reset_values got=%h exp=%h", g, e);
      end
      // Unarmed: ILINE is ignored, nothing ever pulses.
      for (int c = 0; c < 5; c++) begin
         exp_q.push_back(mk(0, 0, 0, 0));
         tick(0, 1);
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (g !== e) begin
            failures++; $display("FAIL wait_ignore c%0d got=%h exp=%h", c, g, e);
         end
      end
      exp_q.push_back(low_exp());
      tick(0, 0);
      e = exp_q.pop_front(); g = sample(e.we); checks++;
      if (g !== e) begin
         failures++; $display("FAIL wait_no_done got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_frame();
      obs_t e, g;
      int wv_cnt;
      exp_q.push_back(vs_exp());
      tick(1, 0);
      e = exp_q.pop_front(); g = sample(e.we); checks++;
      if (g !== e) begin
         failures++; $display("FAIL frame_vsync got=%h exp=%h", g, e);
      end
      for (int ln = 0; ln < 3; ln++) begin
         wv_cnt = 0;
         for (int c = 0; c < 10; c++) begin
            exp_q.push_back((c < 8) ? px_exp() : low_exp());
            tick(0, c < 8);
            e = exp_q.pop_front(); g = sample(e.we); checks++;
            if (WIN_VALID) wv_cnt++;
            if (g !== e) begin
               failures++; $display("FAIL frame l%0d c%0d got=%h exp=%h", ln, c, g, e);
            end
         end
         checks++;
         if (wv_cnt !== ((ln == 2) ? 6 : 0)) begin
            failures++;
            $display("FAIL frame_wv_count l%0d got=%0d exp=%0d", ln, wv_cnt, (ln == 2) ? 6 : 0);
         end
      end
   endtask

   task automatic test_overflow();
      obs_t e, g;
      for (int c = 0; c < L + 5; c++) begin
         exp_q.push_back((c < L + 3) ? px_exp() : low_exp());
         tick(0, c < L + 3);
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (g !== e) begin
            failures++; $display("FAIL ovf_line c%0d got=%h exp=%h", c, g, e);
         end
      end
      checks++;
      if (LINE_LEN !== 10'(L + 3) || OVF !== 1'b1) begin
         failures++;
         $display("FAIL ovf_len got len=%0d ovf=%b exp len=%0d ovf=1", LINE_LEN, OVF, L + 3);
      end
      exp_q.push_back(vs_exp());
      tick(1, 0);
      e = exp_q.pop_front(); g = sample(e.we); checks++;
      if (g !== e) begin
         failures++; $display("FAIL ovf_clear got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_vsync_abort();
      obs_t e, g;
      // Line 0 (8 px + gap), then line 1 cut by VSYNC at pixel 4.
      for (int c = 0; c < 14; c++) begin
         if (c == 13) begin
            exp_q.push_back(vs_exp());
            tick(1, 1);
         end else begin
            exp_q.push_back((c < 8 || c > 8) ? px_exp() : low_exp());
            tick(0, c != 8);
         end
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (g !== e) begin
            failures++; $display("FAIL abort c%0d got=%h exp=%h", c, g, e);
         end
      end
      // Low cycle after abandoned line must not pulse LINE_DONE.
      for (int c = 0; c < 5; c++) begin
         exp_q.push_back((c == 0 || c == 4) ? low_exp() : px_exp());
         tick(0, !(c == 0 || c == 4));
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (g !== e) begin
            failures++; $display("FAIL abort_next c%0d got=%h exp=%h", c, g, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, g;
      int done_cnt;
      done_cnt = 0;
      exp_q.push_back(vs_exp());
      tick(1, 0);
      e = exp_q.pop_front(); g = sample(e.we); checks++;
      if (g !== e) begin
         failures++; $display("FAIL b2b_vsync got=%h exp=%h", g, e);
      end
      for (int c = 0; c < 11; c++) begin
         exp_q.push_back((c == 4 || c >= 9) ? low_exp() : px_exp());
         tick(0, !(c == 4 || c >= 9));
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (LINE_DONE) done_cnt++;
         if (g !== e) begin
            failures++; $display("FAIL b2b c%0d got=%h exp=%h", c, g, e);
         end
      end
      checks++;
      if (done_cnt !== 2 || WBANK !== 2'd2 || LINE_LEN !== 10'd4) begin
         failures++;
         $display("FAIL b2b_summary got done=%0d wbank=%0d len=%0d exp done=2 wbank=2 len=4",
                  done_cnt, WBANK, LINE_LEN);
      end
   endtask

   task automatic test_async_reset();
      obs_t e, g;
      exp_q.push_back(vs_exp());
      tick(1, 0);
      e = exp_q.pop_front(); g = sample(e.we); checks++;
      if (g !== e) begin
         failures++; $display("FAIL arst_vsync got=%h exp=%h", g, e);
      end
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(px_exp());
         tick(0, 1);
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (g !== e) begin
            failures++; $display("FAIL arst_px c%0d got=%h exp=%h", c, g, e);
         end
      end
      // Assert reset between edges, with ILINE still high.
      #2 RST = 1'b1;
      model_reset();
      exp_q.push_back(mk(0, 0, 0, 0));
      #1;
      e = exp_q.pop_front(); g = sample(1'b1); checks++;
      if (g !== e) begin
         failures++; $display("FAIL arst_immediate got=%h exp=%h", g, e);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int c = 0; c < 4; c++) begin
         exp_q.push_back((c < 3) ? mk(0, 0, 0, 0) : low_exp());
         tick(0, c < 3);
         e = exp_q.pop_front(); g = sample(e.we); checks++;
         if (g !== e) begin
            failures++; $display("FAIL arst_ignore c%0d got=%h exp=%h", c, g, e);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame();
      test_overflow();
      test_vsync_abort();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
